// File: rtl/imem_loader.sv
// Byte-stream program loader: packs 3 bytes per instruction word and writes it into the instruction memory.
// Latency: write strobe one cycle after the third byte; done one cycle after the last write (or after the header).
module imem_loader #(
    parameter int ISIZE      = 18,
    parameter int DSIZE      = 16,
    parameter int IMEM_DEPTH = 256,
    parameter bit AUTO_RUN   = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load_start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             imem_we,
    output logic [DSIZE-1:0] imem_addr,
    output logic [ISIZE-1:0] imem_wdata,
    output logic             cpu_run,
    output logic             busy,
    output logic             done,
    output logic             fmt_err,
    output logic             ovf_err
);

    typedef enum logic [2:0] {
        IDLE, CNT_HI, CNT_LO, B0, B1, B2, WRITE, FIN
    } state_t;

    // Bits of byte0 above the instruction's top field must be zero.
    localparam logic [7:0] HI_MASK = 8'(8'hFF << (ISIZE - 16));

    state_t             state, state_nxt;
    logic [15:0]        count;
    logic [DSIZE-1:0]   idx;
    logic [ISIZE-1:8]   acc;
    logic               xfer;
    logic [15:0]        cnt_full;
    logic               idx_in_range;
    logic               last_word;

    assign xfer         = in_valid & in_ready;
    assign cnt_full     = {count[15:8], in_data};
    assign idx_in_range = (32'(idx) < IMEM_DEPTH);
    assign last_word    = ((32'(idx) + 32'd1) == 32'(count));

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) state_nxt = CNT_HI;
            end
            CNT_HI: begin
                in_ready = 1'b1;
                if (xfer) state_nxt = CNT_LO;
            end
            CNT_LO: begin
                in_ready = 1'b1;
                if (xfer) state_nxt = (cnt_full == 16'd0) ? FIN : B0;
            end
            B0: begin
                in_ready = 1'b1;
                if (xfer) state_nxt = B1;
            end
            B1: begin
                in_ready = 1'b1;
                if (xfer) state_nxt = B2;
            end
            B2: begin
                in_ready = 1'b1;
                if (xfer) state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = last_word ? FIN : B0;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            count      <= '0;
            idx        <= '0;
            acc        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_run    <= AUTO_RUN;
            busy       <= 1'b0;
            done       <= 1'b0;
            fmt_err    <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        cpu_run <= 1'b0;
                        busy    <= 1'b1;
                        fmt_err <= 1'b0;
                        ovf_err <= 1'b0;
                        idx     <= '0;
                    end
                end
                CNT_HI: begin
                    if (xfer) count[15:8] <= in_data;
                end
                CNT_LO: begin
                    if (xfer) begin
                        count[7:0] <= in_data;
                        if (cnt_full == 16'd0) done <= 1'b1;
                        else ovf_err <= (32'(cnt_full) > IMEM_DEPTH);
                    end
                end
                B0: begin
                    if (xfer) begin
                        acc[ISIZE-1:16] <= in_data[ISIZE-17:0];
                        if ((in_data & HI_MASK) != 8'd0) fmt_err <= 1'b1;
                    end
                end
                B1: begin
                    if (xfer) acc[15:8] <= in_data;
                end
                B2: begin
                    // Words past the memory depth are still consumed, just not written.
                    if (xfer) begin
                        imem_we    <= idx_in_range;
                        imem_addr  <= idx;
                        imem_wdata <= {acc, in_data};
                    end
                end
                WRITE: begin
                    idx <= idx + 1'b1;
                    if (last_word) done <= 1'b1;
                end
                FIN: begin
                    busy    <= 1'b0;
                    cpu_run <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default-depth instance and a depth-2 instance share one byte stream.
module tb_imem_loader;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        load_start;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        in_ready, imem_we, cpu_run, busy, done, fmt_err, ovf_err;
    logic [15:0] imem_addr;
    logic [17:0] imem_wdata;
    logic        in_ready2, imem_we2, cpu_run2, busy2, done2, fmt_err2, ovf_err2;
    logic [15:0] imem_addr2;
    logic [17:0] imem_wdata2;

    int asserts  = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int we_cyc   = 0;

    logic [33:0] q1[$];
    logic [33:0] q2[$];

    imem_loader dut (
        .Clk(Clk), .Rst(Rst), .load_start(load_start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
        .busy(busy), .done(done), .fmt_err(fmt_err), .ovf_err(ovf_err)
    );

    imem_loader #(.IMEM_DEPTH(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .load_start(load_start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready2), .imem_we(imem_we2),
        .imem_addr(imem_addr2), .imem_wdata(imem_wdata2), .cpu_run(cpu_run2),
        .busy(busy2), .done(done2), .fmt_err(fmt_err2), .ovf_err(ovf_err2)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Write monitors: every strobe must match the oldest expected write.
    always @(negedge Clk) begin
        if (Rst === 1'b1 && imem_we === 1'b1) begin
            logic [33:0] exp1;
            we_cyc = cyc;
            asserts++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL wr1_extra: got addr=%0h data=%0h, required no write", imem_addr, imem_wdata);
            end else begin
                exp1 = q1.pop_front();
                if ({imem_addr, imem_wdata} !== exp1) begin
                    failures++;
                    $display("FAIL wr1_data: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             imem_addr, imem_wdata, exp1[33:18], exp1[17:0]);
                end
            end
            asserts++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL ready_in_write: got in_ready=%b, required 0", in_ready);
            end
        end
        if (Rst === 1'b1 && imem_we2 === 1'b1) begin
            logic [33:0] exp2;
            asserts++;
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL wr2_extra: got addr=%0h data=%0h, required no write", imem_addr2, imem_wdata2);
            end else begin
                exp2 = q2.pop_front();
                if ({imem_addr2, imem_wdata2} !== exp2) begin
                    failures++;
                    $display("FAIL wr2_data: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             imem_addr2, imem_wdata2, exp2[33:18], exp2[17:0]);
                end
            end
        end
        if (Rst === 1'b1 && done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) begin
            failures++;
            $display("FAIL ready_timeout: got in_ready=%b, required 1 within 50 cycles", in_ready);
        end
        @(negedge Clk);
        if (gap) begin
            in_valid = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge Clk);
        load_start = 1'b0;
        done_cnt   = 0;
        asserts++;
        if (busy !== 1'b1 || cpu_run !== 1'b0) begin
            failures++;
            $display("FAIL start_state: got busy=%b cpu_run=%b, required busy=1 cpu_run=0", busy, cpu_run);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        asserts++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL done_timeout: got no done pulse, required one within 20 cycles");
        end
        repeat (3) @(negedge Clk);
        asserts++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL done_count: got %0d pulses, required 1", done_cnt);
        end
        asserts++;
        if (cpu_run !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_done: got cpu_run=%b busy=%b, required cpu_run=1 busy=0", cpu_run, busy);
        end
    endtask

    task automatic check_drained(input string name);
        asserts++;
        if (q1.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL %s_pending: got %0d/%0d writes missing, required 0/0", name, q1.size(), q2.size());
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge Clk);
        asserts++;
        if (cpu_run !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || fmt_err !== 1'b0 || ovf_err !== 1'b0 ||
            imem_addr !== 16'd0 || imem_wdata !== 18'd0) begin
            failures++;
            $display("FAIL reset_vals: got run=%b rdy=%b we=%b busy=%b done=%b fmt=%b ovf=%b addr=%0h data=%0h, required 1 0 0 0 0 0 0 0 0",
                     cpu_run, in_ready, imem_we, busy, done, fmt_err, ovf_err, imem_addr, imem_wdata);
        end
        Rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            asserts++;
            if (cpu_run !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold: got run=%b rdy=%b we=%b busy=%b, required 1 0 0 0",
                         cpu_run, in_ready, imem_we, busy);
            end
        end
    endtask

    task automatic test_two_words(input bit gap, input string name);
        logic [7:0] bytes [8];
        bytes = '{8'h00, 8'h02, 8'h03, 8'h12, 8'h34, 8'h01, 8'hAB, 8'hCD};
        start_load();
        q1.push_back({16'd0, 18'h31234}); q2.push_back({16'd0, 18'h31234});
        q1.push_back({16'd1, 18'h1ABCD}); q2.push_back({16'd1, 18'h1ABCD});
        for (int i = 0; i < 8; i++) send_byte(bytes[i], gap);
        in_valid = 1'b0;
        wait_done();
        asserts++;
        if (done_cyc != we_cyc + 1) begin
            failures++;
            $display("FAIL %s_done_lat: got done at cycle %0d, required %0d", name, done_cyc, we_cyc + 1);
        end
        asserts++;
        if (fmt_err !== 1'b0 || ovf_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_err: got fmt=%b ovf=%b, required 0 0", name, fmt_err, ovf_err);
        end
        check_drained(name);
    endtask

    task automatic test_empty();
        start_load();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        in_valid = 1'b0;
        asserts++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL empty_done: got done=%b after header, required 1", done);
        end
        wait_done();
        check_drained("empty");
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [11];
        bytes = '{8'h00, 8'h03, 8'hFF, 8'h12, 8'h34, 8'h01, 8'hAB, 8'hCD, 8'h02, 8'h00, 8'h01};
        start_load();
        q1.push_back({16'd0, 18'h31234}); q2.push_back({16'd0, 18'h31234});
        q1.push_back({16'd1, 18'h1ABCD}); q2.push_back({16'd1, 18'h1ABCD});
        q1.push_back({16'd2, 18'h20001});
        for (int i = 0; i < 11; i++) send_byte(bytes[i], 1'b0);
        in_valid = 1'b0;
        wait_done();
        asserts++;
        if (ovf_err2 !== 1'b1 || fmt_err2 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_small: got ovf=%b fmt=%b, required 1 1", ovf_err2, fmt_err2);
        end
        asserts++;
        if (ovf_err !== 1'b0 || fmt_err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_large: got ovf=%b fmt=%b, required 0 1", ovf_err, fmt_err);
        end
        check_drained("ovf");
    endtask

    task automatic test_abort();
        logic [7:0] bytes [5];
        start_load();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h12, 1'b0);
        in_valid = 1'b0;
        Rst = 1'b0;
        @(negedge Clk);
        asserts++;
        if (busy !== 1'b0 || cpu_run !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: got busy=%b run=%b rdy=%b we=%b, required 0 1 0 0",
                     busy, cpu_run, in_ready, imem_we);
        end
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        bytes = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h01};
        start_load();
        q1.push_back({16'd0, 18'h20001}); q2.push_back({16'd0, 18'h20001});
        for (int i = 0; i < 5; i++) send_byte(bytes[i], 1'b0);
        in_valid = 1'b0;
        wait_done();
        check_drained("abort");
    endtask

    initial begin
        test_reset();
        test_two_words(1'b0, "stream");
        test_two_words(1'b1, "toggle");
        test_empty();
        test_overflow();
        test_abort();
        repeat (5) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
